// File: rtl/melody_player.sv
// Single-channel melody sequencer: walks a note ROM of {last, dur, div} entries,
// generates a square tone per note, times it in DUR_TICK units and inserts a silent gap.
module melody_player #(
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 8,
  parameter int ADDR_W    = 5,
  parameter int DUR_TICK  = 120000,
  parameter int GAP_UNITS = 1,
  parameter int LOOP      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DIV_W+DUR_W:0]   rom_data,
  output logic                   ch_out,
  output logic                   busy,
  output logic                   done
);

  localparam int PRE_W  = (DUR_TICK > 1) ? $clog2(DUR_TICK) : 1;
  localparam int GAP_W  = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam int UNIT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DUR_TICK - 1);
  localparam logic [UNIT_W-1:0] GAP_LAST = UNIT_W'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_phase;
  logic [DUR_W-1:0]   r_dur;
  logic               r_last;
  logic [PRE_W-1:0]   r_pre;
  logic [UNIT_W-1:0]  r_unit;
  logic               r_ch;
  logic               r_busy;
  logic               r_done;

  logic [DIV_W-1:0]   w_rom_div;
  logic [DUR_W-1:0]   w_rom_dur;
  logic               w_rom_last;
  logic [UNIT_W-1:0]  w_dur_last;
  logic               w_tick;
  logic               w_play_end;
  logic               w_gap_end;
  logic               w_skip;
  logic               w_advance;
  logic               w_adv_last;
  logic               w_tone_edge;

  assign w_rom_div   = rom_data[DIV_W-1:0];
  assign w_rom_dur   = rom_data[DIV_W +: DUR_W];
  assign w_rom_last  = rom_data[DIV_W+DUR_W];
  assign w_dur_last  = UNIT_W'(r_dur) - UNIT_W'(1);
  assign w_tick      = (r_pre == PRE_LAST);
  assign w_play_end  = (r_state == PLAY) && w_tick && (r_unit == w_dur_last);
  assign w_gap_end   = (r_state == GAP) && w_tick && (r_unit == GAP_LAST);
  assign w_skip      = (r_state == LOAD) && (w_rom_dur == '0);
  assign w_tone_edge = (r_phase == r_div - 1'b1);

  // A zero-duration entry advances straight from LOAD, so its last flag is
  // taken from the ROM word rather than the (not yet loaded) register.
  assign w_advance  = w_skip || w_gap_end || (w_play_end && (GAP_UNITS == 0));
  assign w_adv_last = (r_state == LOAD) ? w_rom_last : r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_div   <= '0;
      r_phase <= '0;
      r_dur   <= '0;
      r_last  <= 1'b0;
      r_pre   <= '0;
      r_unit  <= '0;
      r_ch    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && stop) begin
        r_state <= IDLE;
        r_ch    <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_advance) begin
        r_ch <= 1'b0;
        if (!w_adv_last) begin
          r_addr  <= r_addr + 1'b1;
          r_state <= FETCH;
        end else if (LOOP != 0) begin
          r_addr  <= '0;
          r_state <= FETCH;
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !stop) begin
              r_state <= FETCH;
              r_addr  <= '0;
              r_busy  <= 1'b1;
            end
          end
          FETCH: r_state <= LOAD;
          LOAD: begin
            r_div   <= w_rom_div;
            r_dur   <= w_rom_dur;
            r_last  <= w_rom_last;
            r_pre   <= '0;
            r_unit  <= '0;
            r_phase <= '0;
            r_ch    <= 1'b0;
            r_state <= PLAY;
          end
          PLAY: begin
            if (w_play_end) begin
              r_state <= GAP;
              r_pre   <= '0;
              r_unit  <= '0;
              r_ch    <= 1'b0;
            end else begin
              if (w_tick) begin
                r_pre  <= '0;
                r_unit <= r_unit + 1'b1;
              end else begin
                r_pre <= r_pre + 1'b1;
              end
              if (r_div == '0) begin
                r_ch <= 1'b0;
              end else if (w_tone_edge) begin
                r_ch    <= ~r_ch;
                r_phase <= '0;
              end else begin
                r_phase <= r_phase + 1'b1;
              end
            end
          end
          GAP: begin
            r_ch <= 1'b0;
            if (w_tick) begin
              r_pre  <= '0;
              r_unit <= r_unit + 1'b1;
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rom_addr = r_addr;
  assign ch_out   = r_ch;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: a trace-generating note model predicts every output cycle,
// driven by directed scenarios and randomized ROM contents on a LOOP=0 and a LOOP=1 instance.
module tb_melody_player;
  localparam int T = 4;
  localparam int G = 1;

  typedef struct packed {
    logic [4:0] addr;
    logic       ch;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
  logic [4:0]  addr0, addr1;
  logic [24:0] rd0, rd1;
  logic ch0, ch1, busy0, busy1, done0, done1;
  logic [24:0] rom [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd0 <= rom[addr0];
    rd1 <= rom[addr1];
  end

  melody_player #(.DIV_W(16), .DUR_W(8), .ADDR_W(5), .DUR_TICK(T), .GAP_UNITS(G), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .rom_addr(addr0),
    .rom_data(rd0), .ch_out(ch0), .busy(busy0), .done(done0));

  melody_player #(.DIV_W(16), .DUR_W(8), .ADDR_W(5), .DUR_TICK(T), .GAP_UNITS(G), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .rom_addr(addr1),
    .rom_data(rd1), .ch_out(ch1), .busy(busy1), .done(done1));

  exp_t q0[$], q1[$], tq[$];
  exp_t idle0, idle1, t_idle;
  logic [4:0] last0, last1, prev1;
  int total = 0, bad = 0;
  int n_busy0 = 0, n_hi0 = 0, n_done0 = 0, n_done1 = 0, n_wrap1 = 0;

  function automatic exp_t mk_e(int a, bit c, bit b, bit d);
    exp_t e;
    e.addr = 5'(a);
    e.ch   = c;
    e.busy = b;
    e.done = d;
    return e;
  endfunction

  function automatic logic [24:0] mk_rom(bit l, int d, int v);
    return {l, 8'(d), 16'(v)};
  endfunction

  task automatic cmp(string nm, exp_t act, exp_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s t=%0t got addr=%0d ch=%0b busy=%0b done=%0b expected addr=%0d ch=%0b busy=%0b done=%0b",
               nm, $time, act.addr, act.ch, act.busy, act.done, e.addr, e.ch, e.busy, e.done);
    end
  endtask

  task automatic chk(string nm, int act, int e);
    total++;
    if (act != e) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, e);
    end
  endtask

  // Expected per-cycle outputs from the start edge onward, derived note by note.
  task automatic build(bit loop, int maxlen);
    int a, d, v;
    bit fin;
    logic [24:0] e;
    a = 0;
    fin = 1'b0;
    tq.push_back(mk_e(a, 0, 1, 0));
    while (!fin && tq.size() < maxlen) begin
      tq.push_back(mk_e(a, 0, 1, 0));
      e = rom[a];
      v = int'(e[15:0]);
      d = int'(e[23:16]);
      for (int k = 0; k < d * T; k++) tq.push_back(mk_e(a, (v != 0) && (((k / v) % 2) == 1), 1, 0));
      if (d > 0) for (int k = 0; k < G * T; k++) tq.push_back(mk_e(a, 0, 1, 0));
      if (!e[24]) begin
        a = (a + 1) % 32;
        tq.push_back(mk_e(a, 0, 1, 0));
      end else if (loop) begin
        a = 0;
        tq.push_back(mk_e(a, 0, 1, 0));
      end else begin
        tq.push_back(mk_e(a, 0, 0, 1));
        fin = 1'b1;
      end
    end
    t_idle = mk_e(a, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q0.size() > 0) e = q0.pop_front(); else e = idle0;
      last0 = e.addr;
      cmp("dut0", {addr0, ch0, busy0, done0}, e);
      if (busy0) n_busy0++;
      if (ch0) n_hi0++;
      if (done0) n_done0++;
      if (q1.size() > 0) e = q1.pop_front(); else e = idle1;
      last1 = e.addr;
      cmp("dut1", {addr1, ch1, busy1, done1}, e);
      if (done1) n_done1++;
      if (prev1 == 5'd1 && addr1 == 5'd0) n_wrap1++;
      prev1 = addr1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(bit loop, int maxlen);
    tq.delete();
    build(loop, maxlen);
    foreach (tq[i]) q0.push_back(tq[i]);
    idle0 = t_idle;
  endtask

  task automatic start_pulse0(int maxlen);
    start0 = 1'b1;
    push0(1'b0, maxlen);
    tick();
    start0 = 1'b0;
  endtask

  task automatic drain0(int budget);
    for (int i = 0; i < budget && q0.size() != 0; i++) tick();
    chk("drain0", q0.size(), 0);
  endtask

  task automatic stop_now0();
    stop0 = 1'b1;
    q0.delete();
    idle0 = mk_e(int'(last0), 0, 0, 0);
    tick();
    stop0 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, mode, hi, found;
    foreach (rom[i]) rom[i] = '0;
    idle0 = mk_e(0, 0, 0, 0);
    idle1 = mk_e(0, 0, 0, 0);
    prev1 = '0;
    #12;
    chk("rst_addr", int'(addr0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_ch", int'(ch0), 0);
    tick();
    rst = 1'b0;

    // Basic two-note melody, model pinned by hand-counted figures.
    rom[0] = mk_rom(0, 3, 5);
    rom[1] = mk_rom(1, 2, 0);
    tq.delete();
    build(1'b0, 1000);
    hi = 0;
    foreach (tq[i]) if (tq[i].ch) hi++;
    chk("model_len", tq.size(), 33);
    chk("model_hi", hi, 5);
    n_busy0 = 0; n_hi0 = 0; n_done0 = 0;
    start_pulse0(1000);
    drain0(100);
    tick();
    chk("t1_busy_cycles", n_busy0, 32);
    chk("t1_hi_cycles", n_hi0, 5);
    chk("t1_done_pulses", n_done0, 1);

    // start and stop together in IDLE
    start0 = 1'b1; stop0 = 1'b1;
    tick();
    start0 = 1'b0; stop0 = 1'b0;
    chk("ss_busy", int'(busy0), 0);
    tick();

    // stop in the middle of PLAY, then replay
    start_pulse0(1000);
    tick(); tick();
    repeat (6) tick();
    chk("pre_stop_ch", int'(ch0), 1);
    n_done0 = 0;
    stop_now0();
    chk("stop_ch", int'(ch0), 0);
    chk("stop_busy", int'(busy0), 0);
    repeat (5) tick();
    chk("stop_no_done", n_done0, 0);
    n_done0 = 0;
    start_pulse0(1000);
    drain0(100);
    tick();
    chk("replay_done", n_done0, 1);

    // async reset while the second note is sounding
    rom[0] = mk_rom(0, 1, 5);
    rom[1] = mk_rom(1, 2, 3);
    start_pulse0(1000);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (addr0 == 5'd1 && ch0) found = 1; else tick();
    end
    chk("rst_mid_found", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", int'(addr0), 0);
    chk("arst_ch", int'(ch0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_done", int'(done0), 0);
    q0.delete(); q1.delete();
    idle0 = mk_e(0, 0, 0, 0);
    idle1 = mk_e(0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // zero-duration entry is skipped
    rom[0] = mk_rom(0, 0, 7);
    rom[1] = mk_rom(1, 1, 2);
    start_pulse0(1000);
    tick(); tick();
    chk("skip_addr", int'(addr0), 1);
    drain0(100);

    // div=1 with a start pulse during PLAY
    rom[0] = mk_rom(1, 2, 1);
    n_hi0 = 0;
    start_pulse0(1000);
    repeat (5) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    drain0(100);
    chk("div1_hi", n_hi0, 4);

    // start held across done restarts immediately
    rom[0] = mk_rom(0, 3, 5);
    rom[1] = mk_rom(1, 2, 0);
    n_done0 = 0;
    start0 = 1'b1;
    push0(1'b0, 1000);
    tq.delete();
    build(1'b0, 1000);
    foreach (tq[i]) q0.push_back(tq[i]);
    repeat (36) tick();
    start0 = 1'b0;
    drain0(100);
    tick();
    chk("held_done", n_done0, 2);

    // randomized ROM contents
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 32; i++) rom[i] = mk_rom(0, $urandom_range(0, 3), $urandom_range(0, 6));
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        for (int i = 0; i < 32; i++) rom[i] = mk_rom(0, 0, $urandom_range(0, 6));
        rom[5] = mk_rom(0, 1, $urandom_range(1, 3));
        start_pulse0(400);
        repeat (150) tick();
        stop_now0();
      end else begin
        rom[$urandom_range(0, 6)][24] = 1'b1;
        start_pulse0(1000);
        len = q0.size();
        if (mode == 1 && len > 1) begin
          repeat ($urandom_range(1, len - 1)) tick();
          stop_now0();
        end else begin
          drain0(len + 10);
        end
      end
      repeat (2) tick();
    end

    // LOOP=1 instance replays the melody without done
    rom[0] = mk_rom(0, 3, 5);
    rom[1] = mk_rom(1, 2, 0);
    n_done1 = 0; n_wrap1 = 0;
    start1 = 1'b1;
    tq.delete();
    build(1'b1, 3 * 32 + 10);
    foreach (tq[i]) q1.push_back(tq[i]);
    tick();
    start1 = 1'b0;
    repeat (97) tick();
    stop1 = 1'b1;
    q1.delete();
    idle1 = mk_e(int'(last1), 0, 0, 0);
    tick();
    stop1 = 1'b0;
    chk("loop_no_done", n_done1, 0);
    chk("loop_wraps", n_wrap1, 3);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
